// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, the data port and the single-port memory bus.
// The arbiter uses the slave view; requesters and the memory use the master view.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        if_stall;

  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_done;
  logic [31:0] dm_rdata;
  logic        dm_stall;

  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic        busy;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_done, if_rdata, if_stall, dm_done, dm_rdata, dm_stall,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_done, if_rdata, if_stall, dm_done, dm_rdata, dm_stall,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port I/D memory between the fetch and data stages.
// Define ARB_FAIR_EN to let a starved fetch win after STARVE_LIMIT data grants.
//
// state | meaning
// IDLE  | no access in flight; arbitrate and latch the winner's request
// ISSUE | one-cycle memory strobe with the latched address/we/wdata
// WAIT  | count down MEM_LAT cycles; capture read data on the last one
// DONE  | one-cycle done pulse to the owner, then back to IDLE
module mem_port_arbiter #(
  parameter int MEM_LAT      = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t      state;
  state_t      state_nxt;
  logic        owner_dm;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] if_rdata_q;
  logic [31:0] dm_rdata_q;
  logic [3:0]  lat_cnt;
  logic        any_req;
  logic        grant_dm;

  assign any_req = bus.if_req | bus.dm_req;

`ifdef ARB_FAIR_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] starve_cnt;
  logic          if_forced;

  assign if_forced = bus.if_req && (starve_cnt == SW'(STARVE_LIMIT));
  assign grant_dm  = bus.dm_req && !if_forced;

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (state == IDLE && any_req) begin
      if (!grant_dm) begin
        starve_cnt <= '0;
      end else if (bus.if_req && starve_cnt != SW'(STARVE_LIMIT)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end
`else
  logic unused_starve_limit;

  assign unused_starve_limit = (STARVE_LIMIT > 0);
  assign grant_dm            = bus.dm_req;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    bus.mem_en   = 1'b0;
    bus.if_done  = 1'b0;
    bus.dm_done  = 1'b0;
    bus.busy     = (state != IDLE);
    case (state)
      IDLE:  if (any_req) state_nxt = ISSUE;
      ISSUE: begin
        bus.mem_en = 1'b1;
        state_nxt  = WAIT;
      end
      WAIT:  if (lat_cnt == 4'd1) state_nxt = DONE;
      DONE: begin
        bus.if_done = !owner_dm;
        bus.dm_done = owner_dm;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    bus.if_stall = bus.if_req & ~bus.if_done;
    bus.dm_stall = bus.dm_req & ~bus.dm_done;
  end

  // Request fields are frozen at grant so requester-side changes cannot
  // disturb an access already in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_dm   <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      lat_cnt    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner_dm <= grant_dm;
            if (grant_dm) begin
              we_q    <= bus.dm_we;
              addr_q  <= bus.dm_addr;
              wdata_q <= bus.dm_wdata;
            end else begin
              we_q    <= 1'b0;
              addr_q  <= bus.if_addr;
            end
          end
        end
        ISSUE: lat_cnt <= 4'(MEM_LAT);
        WAIT: begin
          lat_cnt <= lat_cnt - 4'd1;
          if (lat_cnt == 4'd1) begin
            if (!owner_dm) begin
              if_rdata_q <= bus.mem_rdata;
            end else if (!we_q) begin
              dm_rdata_q <= bus.mem_rdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: three instances (MEM_LAT 2, 1, 15)
// each fed by a memory model that drives valid data only in the exact return cycle.
module tb_mem_port_arbiter;

  logic clk;
  logic reset;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  logic        if_req   [3];
  logic [31:0] if_addr  [3];
  logic        dm_req   [3];
  logic        dm_we    [3];
  logic [31:0] dm_addr  [3];
  logic [31:0] dm_wdata [3];

  logic        if_done_m  [3];
  logic [31:0] if_rdata_m [3];
  logic        if_stall_m [3];
  logic        dm_done_m  [3];
  logic [31:0] dm_rdata_m [3];
  logic        dm_stall_m [3];
  logic        mem_en_m   [3];
  logic        mem_we_m   [3];
  logic [31:0] mem_addr_m [3];
  logic [31:0] mem_wdata_m[3];
  logic        busy_m     [3];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h8C21FFC4 + a;
  endfunction

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 15);
    mem_port_arbiter_if bus ();
    logic [31:0] issue_addr = '0;
    int          issue_cyc = -100;

    mem_port_arbiter #(.MEM_LAT(LAT), .STARVE_LIMIT(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
    );

    assign bus.if_req   = if_req[g];
    assign bus.if_addr  = if_addr[g];
    assign bus.dm_req   = dm_req[g];
    assign bus.dm_we    = dm_we[g];
    assign bus.dm_addr  = dm_addr[g];
    assign bus.dm_wdata = dm_wdata[g];

    assign if_done_m[g]   = bus.if_done;
    assign if_rdata_m[g]  = bus.if_rdata;
    assign if_stall_m[g]  = bus.if_stall;
    assign dm_done_m[g]   = bus.dm_done;
    assign dm_rdata_m[g]  = bus.dm_rdata;
    assign dm_stall_m[g]  = bus.dm_stall;
    assign mem_en_m[g]    = bus.mem_en;
    assign mem_we_m[g]    = bus.mem_we;
    assign mem_addr_m[g]  = bus.mem_addr;
    assign mem_wdata_m[g] = bus.mem_wdata;
    assign busy_m[g]      = bus.busy;

    always @(posedge clk) begin
      if (bus.mem_en) begin
        issue_cyc  <= cyc;
        issue_addr <= bus.mem_addr;
      end
    end

    // Any capture outside the exact return cycle picks up this filler pattern.
    assign bus.mem_rdata = (cyc == issue_cyc + LAT) ? mem_word(issue_addr)
                                                    : (32'h5A5A0000 ^ 32'(cyc));
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        n_checks++;
        if ({busy_m[g], mem_en_m[g], mem_we_m[g], if_done_m[g], dm_done_m[g]} !== 5'b0 ||
            mem_addr_m[g] !== 32'h0 || mem_wdata_m[g] !== 32'h0 ||
            if_rdata_m[g] !== 32'h0 || dm_rdata_m[g] !== 32'h0)
          $display("FAIL reset inst=%0d: busy=%b en=%b we=%b ifd=%b dmd=%b addr=%h wdata=%h ifr=%h dmr=%h, required all zero",
                   g, busy_m[g], mem_en_m[g], mem_we_m[g], if_done_m[g], dm_done_m[g],
                   mem_addr_m[g], mem_wdata_m[g], if_rdata_m[g], dm_rdata_m[g]);
        else n_pass++;
      end
    end
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy_m[0], mem_en_m[0], if_stall_m[0], dm_stall_m[0]} !== 4'b0)
      $display("FAIL reset_release: busy/en/ifstall/dmstall=%b required 0000",
               {busy_m[0], mem_en_m[0], if_stall_m[0], dm_stall_m[0]});
    else n_pass++;
  endtask

  task automatic test_if_read();
    next_cycle();
    if_req[0]  = 1'b1;
    if_addr[0] = 32'h40;
    for (int c = 0; c < 6; c++) begin
      if (c == 5) if_req[0] = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({mem_en_m[0], if_done_m[0], if_stall_m[0], busy_m[0]} !==
          {c == 1, c == 4, c <= 3, (c >= 1 && c <= 4)})
        $display("FAIL if_read_ctrl c=%0d: en/done/stall/busy=%b required %b", c,
                 {mem_en_m[0], if_done_m[0], if_stall_m[0], busy_m[0]},
                 {c == 1, c == 4, c <= 3, (c >= 1 && c <= 4)});
      else n_pass++;
      if (c == 1) begin
        n_checks++;
        if (mem_addr_m[0] !== 32'h40 || mem_we_m[0] !== 1'b0)
          $display("FAIL if_read_issue: addr=%h we=%b required 00000040 0", mem_addr_m[0], mem_we_m[0]);
        else n_pass++;
      end
      if (c == 4) begin
        n_checks++;
        if (if_rdata_m[0] !== 32'h8C220004)
          $display("FAIL if_read_data: got %h required 8c220004", if_rdata_m[0]);
        else n_pass++;
      end
      next_cycle();
    end
  endtask

  task automatic test_load();
    next_cycle();
    dm_req[0]  = 1'b1;
    dm_we[0]   = 1'b0;
    dm_addr[0] = 32'h80;
    for (int c = 0; c < 6; c++) begin
      if (c == 5) dm_req[0] = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({mem_en_m[0], dm_done_m[0], dm_stall_m[0], if_done_m[0]} !== {c == 1, c == 4, c <= 3, 1'b0})
        $display("FAIL load_ctrl c=%0d: en/dmdone/dmstall/ifdone=%b required %b", c,
                 {mem_en_m[0], dm_done_m[0], dm_stall_m[0], if_done_m[0]}, {c == 1, c == 4, c <= 3, 1'b0});
      else n_pass++;
      if (c == 4) begin
        n_checks++;
        if (dm_rdata_m[0] !== 32'h8C220044)
          $display("FAIL load_data: got %h required 8c220044", dm_rdata_m[0]);
        else n_pass++;
      end
      next_cycle();
    end
  endtask

  task automatic test_store();
    next_cycle();
    dm_req[0]   = 1'b1;
    dm_we[0]    = 1'b1;
    dm_addr[0]  = 32'h100;
    dm_wdata[0] = 32'hDEADBEEF;
    for (int c = 0; c < 6; c++) begin
      if (c == 2) begin
        dm_addr[0]  = 32'h200;
        dm_wdata[0] = 32'h0;
      end
      if (c == 5) dm_req[0] = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({mem_en_m[0], dm_done_m[0]} !== {c == 1, c == 4})
        $display("FAIL store_ctrl c=%0d: en/dmdone=%b required %b", c,
                 {mem_en_m[0], dm_done_m[0]}, {c == 1, c == 4});
      else n_pass++;
      if (c == 1 || c == 3) begin
        n_checks++;
        if (mem_we_m[0] !== 1'b1 || mem_addr_m[0] !== 32'h100 || mem_wdata_m[0] !== 32'hDEADBEEF)
          $display("FAIL store_bus c=%0d: we=%b addr=%h wdata=%h required 1 00000100 deadbeef",
                   c, mem_we_m[0], mem_addr_m[0], mem_wdata_m[0]);
        else n_pass++;
      end
      if (c >= 4) begin
        n_checks++;
        if (dm_rdata_m[0] !== 32'h8C220044)
          $display("FAIL store_rdata c=%0d: got %h required 8c220044", c, dm_rdata_m[0]);
        else n_pass++;
      end
      next_cycle();
    end
  endtask

  task automatic test_collision();
    int n_en;
    n_en = 0;
    next_cycle();
    if_req[0]  = 1'b1;
    if_addr[0] = 32'h44;
    dm_req[0]  = 1'b1;
    dm_we[0]   = 1'b0;
    dm_addr[0] = 32'h90;
    for (int c = 0; c < 11; c++) begin
      if (c == 5)  dm_req[0] = 1'b0;
      if (c == 10) if_req[0] = 1'b0;
      @(negedge clk);
      if (mem_en_m[0]) n_en++;
      n_checks++;
      if ({mem_en_m[0], dm_done_m[0], if_done_m[0]} !== {(c == 1 || c == 6), c == 4, c == 9})
        $display("FAIL collision_ctrl c=%0d: en/dmdone/ifdone=%b required %b", c,
                 {mem_en_m[0], dm_done_m[0], if_done_m[0]}, {(c == 1 || c == 6), c == 4, c == 9});
      else n_pass++;
      next_cycle();
    end
    n_checks++;
    if (n_en !== 2) $display("FAIL collision_strobes: got %0d required 2", n_en);
    else n_pass++;
    n_checks++;
    if (if_rdata_m[0] !== 32'h8C220008 || dm_rdata_m[0] !== 32'h8C220054)
      $display("FAIL collision_data: if=%h dm=%h required 8c220008 8c220054", if_rdata_m[0], dm_rdata_m[0]);
    else n_pass++;
  endtask

  task automatic test_starve();
    int first_if;
    int n_dm_before;
    int exp_first;
    int exp_n;
`ifdef ARB_FAIR_EN
    exp_first = 24;
    exp_n     = 4;
`else
    exp_first = -1;
    exp_n     = 6;
`endif
    first_if    = -1;
    n_dm_before = 0;
    next_cycle();
    if_req[0]  = 1'b1;
    if_addr[0] = 32'h60;
    dm_req[0]  = 1'b1;
    dm_we[0]   = 1'b0;
    dm_addr[0] = 32'h70;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (dm_done_m[0] && first_if < 0) n_dm_before++;
      if (if_done_m[0] && first_if < 0) first_if = c;
      next_cycle();
    end
    if_req[0] = 1'b0;
    dm_req[0] = 1'b0;
    n_checks++;
    if (n_dm_before !== exp_n)
      $display("FAIL starve_dm_count: got %0d required %0d", n_dm_before, exp_n);
    else n_pass++;
    n_checks++;
    if (first_if !== exp_first)
      $display("FAIL starve_if_done_cycle: got %0d required %0d", first_if, exp_first);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (busy_m[0] !== 1'b0) $display("FAIL starve_idle: busy=%b required 0", busy_m[0]);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int n_done;
    n_done = 0;
    next_cycle();
    if_req[0]  = 1'b1;
    if_addr[0] = 32'h48;
    next_cycle();
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset     = 1'b0;
    if_req[0] = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy_m[0] !== 1'b0 || mem_en_m[0] !== 1'b0 || if_rdata_m[0] !== 32'h0 || mem_addr_m[0] !== 32'h0)
      $display("FAIL reset_mid_state: busy=%b en=%b ifr=%h addr=%h required 0 0 0 0",
               busy_m[0], mem_en_m[0], if_rdata_m[0], mem_addr_m[0]);
    else n_pass++;
    for (int c = 0; c < 6; c++) begin
      if (if_done_m[0]) n_done++;
      next_cycle();
      @(negedge clk);
    end
    n_checks++;
    if (n_done !== 0) $display("FAIL reset_mid_no_done: got %0d pulses required 0", n_done);
    else n_pass++;
    next_cycle();
    if_req[0]  = 1'b1;
    if_addr[0] = 32'h4C;
    for (int c = 0; c < 6; c++) begin
      if (c == 5) if_req[0] = 1'b0;
      @(negedge clk);
      n_checks++;
      if (if_done_m[0] !== (c == 4))
        $display("FAIL reset_mid_fresh_done c=%0d: got %b required %b", c, if_done_m[0], c == 4);
      else n_pass++;
      if (c == 4) begin
        n_checks++;
        if (if_rdata_m[0] !== 32'h8C220010)
          $display("FAIL reset_mid_fresh_data: got %h required 8c220010", if_rdata_m[0]);
        else n_pass++;
      end
      next_cycle();
    end
  endtask

  task automatic test_sweep();
    int lat;
    int k;
    for (int g = 1; g < 3; g++) begin
      lat = (g == 1) ? 1 : 15;
      k   = 0;
      next_cycle();
      if_req[g]  = 1'b1;
      if_addr[g] = 32'h200;
      for (int c = 0; c < 3 * (lat + 3) + 5 && k < 3; c++) begin
        @(negedge clk);
        if (if_done_m[g]) begin
          n_checks++;
          if (c !== lat + 2 + k * (lat + 3))
            $display("FAIL sweep_spacing lat=%0d k=%0d: done at %0d required %0d",
                     lat, k, c, lat + 2 + k * (lat + 3));
          else n_pass++;
          n_checks++;
          if (if_rdata_m[g] !== mem_word(32'h200 + 32'(4 * k)))
            $display("FAIL sweep_data lat=%0d k=%0d: got %h required %h",
                     lat, k, if_rdata_m[g], mem_word(32'h200 + 32'(4 * k)));
          else n_pass++;
          k++;
          next_cycle();
          if_addr[g] = 32'h200 + 32'(4 * k);
          if (k == 3) if_req[g] = 1'b0;
        end else begin
          next_cycle();
        end
      end
      if_req[g] = 1'b0;
      n_checks++;
      if (k !== 3) $display("FAIL sweep_count lat=%0d: got %0d completions required 3", lat, k);
      else n_pass++;
    end
  endtask

  initial begin
    clk   = 1'b0;
    reset = 1'b1;
    for (int g = 0; g < 3; g++) begin
      if_req[g]   = 1'b0;
      if_addr[g]  = '0;
      dm_req[g]   = 1'b0;
      dm_we[g]    = 1'b0;
      dm_addr[g]  = '0;
      dm_wdata[g] = '0;
    end
    test_reset();
    test_if_read();
    test_load();
    test_store();
    test_collision();
    test_starve();
    test_reset_mid();
    test_sweep();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
